// File: rtl/core101_pkg.sv
// Shared constants and types for the core101 instruction-fetch sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package core101_pkg;

  // Datapath PC mux select encodings
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;  // PC + 4
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;  // branch target
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;  // jump / ALU result
  localparam logic [1:0] PC_SRC_TRAP   = 2'b11;  // trap vector

  typedef enum logic [2:0] {
    REQ   = 3'd0,
    WAIT  = 3'd1,
    FLUSH = 3'd2,
    HOLD  = 3'd3,
    ERROR = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/core101_fetch_timeout_cnt.sv
// Saturating wait-cycle counter; flags expiry once TIMEOUT_CYCLES is reached.
// Latency: count updates one cycle after clr/inc; expired is a decode of the count.
// Backpressure: none; clr has priority over inc.
//
// Ports:
//   core_clk  clock, rising edge
//   arst      asynchronous active-high reset
//   clr       return count to zero
//   inc       advance count (holds at TIMEOUT_CYCLES)
//   expired   count has reached TIMEOUT_CYCLES
module core101_fetch_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TO_WIDTH       = 8
) (
  input  logic core_clk,
  input  logic arst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

  logic [TO_WIDTH-1:0] count;

  // Saturate at LIMIT so a request that lingers past the limit (e.g. a
  // redirect turning WAIT into FLUSH on the expiry cycle) still reads expired.
  always_ff @(posedge core_clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + TO_WIDTH'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/core101_fetch_sequencer.sv
// Multi-cycle fetch controller: drives PC/IR enables and the imem request handshake.
// Latency: zero-wait memory gives one instruction every 2 cycles (REQ -> HOLD -> REQ).
// Backpressure: decode stall holds the IR in HOLD; imem ready is waited on up to TIMEOUT_CYCLES.
//
// Ports:
//   fetch_seq_clock_in / fetch_seq_reset_in   clock, async active-high reset
//   fetch_seq_imem_req_out / _imem_ready_in   instruction memory handshake
//   fetch_seq_stall_in                        decode cannot take the IR
//   fetch_seq_redirect_valid_in / _src_in     PC redirect from execute
//   fetch_seq_pc_set_val_out / _pc_src_out    datapath PC write enable and mux select
//   fetch_seq_ir_set_val_out                  datapath IR load enable
//   fetch_seq_ir_valid_out                    IR holds an unconsumed instruction
//   fetch_seq_err_out                         sticky fetch timeout error
// Optional: define CORE101_FETCH_PERF_EN to add fetch_seq_perf_ins_out and
// fetch_seq_perf_stall_out (32-bit wrapping instruction / stall counters).
module core101_fetch_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TO_WIDTH       = 8
) (
  input  logic        fetch_seq_clock_in,
  input  logic        fetch_seq_reset_in,
  output logic        fetch_seq_imem_req_out,
  input  logic        fetch_seq_imem_ready_in,
  input  logic        fetch_seq_stall_in,
  input  logic        fetch_seq_redirect_valid_in,
  input  logic [1:0]  fetch_seq_redirect_src_in,
  output logic        fetch_seq_pc_set_val_out,
  output logic [1:0]  fetch_seq_pc_src_out,
  output logic        fetch_seq_ir_set_val_out,
  output logic        fetch_seq_ir_valid_out,
  output logic        fetch_seq_err_out
`ifdef CORE101_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_seq_perf_ins_out,
  output logic [31:0] fetch_seq_perf_stall_out
`endif
);

  import core101_pkg::*;

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic         expired;
  logic         pc_set;
  logic [1:0]   pc_src;
  logic         ir_set;
  logic         cnt_inc;

  always_comb begin
    state_nxt = state;
    pc_set    = 1'b0;
    pc_src    = PC_SRC_SEQ;
    ir_set    = 1'b0;
    case (state)
      REQ: begin
        if (fetch_seq_redirect_valid_in) begin
          pc_set    = 1'b1;
          pc_src    = fetch_seq_redirect_src_in;
          // A response landing with the redirect is stale: drop it and refetch.
          state_nxt = fetch_seq_imem_ready_in ? REQ : FLUSH;
        end else if (fetch_seq_imem_ready_in) begin
          ir_set    = 1'b1;
          state_nxt = HOLD;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (fetch_seq_redirect_valid_in) begin
          pc_set    = 1'b1;
          pc_src    = fetch_seq_redirect_src_in;
          state_nxt = fetch_seq_imem_ready_in ? REQ : FLUSH;
        end else if (fetch_seq_imem_ready_in) begin
          ir_set    = 1'b1;
          state_nxt = HOLD;
        end else if (expired) begin
          state_nxt = ERROR;
        end
      end
      FLUSH: begin
        // Outstanding request must still drain; its data is never loaded.
        if (fetch_seq_redirect_valid_in) begin
          pc_set = 1'b1;
          pc_src = fetch_seq_redirect_src_in;
        end
        if (fetch_seq_imem_ready_in) begin
          state_nxt = REQ;
        end else if (expired) begin
          state_nxt = ERROR;
        end
      end
      HOLD: begin
        if (fetch_seq_redirect_valid_in) begin
          pc_set    = 1'b1;
          pc_src    = fetch_seq_redirect_src_in;
          state_nxt = REQ;
        end else if (!fetch_seq_stall_in) begin
          pc_set    = 1'b1;
          pc_src    = PC_SRC_SEQ;
          state_nxt = REQ;
        end
      end
      ERROR: begin
        // Only a trap redirect can recover the fetch unit.
        if (fetch_seq_redirect_valid_in && (fetch_seq_redirect_src_in == PC_SRC_TRAP)) begin
          pc_set    = 1'b1;
          pc_src    = PC_SRC_TRAP;
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge fetch_seq_clock_in or posedge fetch_seq_reset_in) begin
    if (fetch_seq_reset_in) begin
      state <= REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Count only while a request is outstanding; REQ->WAIT therefore lands on 1.
  assign cnt_inc = (state_nxt == WAIT) || (state_nxt == FLUSH);

  core101_fetch_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) u_timeout (
    .core_clk (fetch_seq_clock_in),
    .arst     (fetch_seq_reset_in),
    .clr      (!cnt_inc),
    .inc      (cnt_inc),
    .expired  (expired)
  );

  // Write enables are masked during reset so no PC/IR update escapes it.
  assign fetch_seq_imem_req_out   = (state == REQ) || (state == WAIT) || (state == FLUSH);
  assign fetch_seq_pc_set_val_out = pc_set && !fetch_seq_reset_in;
  assign fetch_seq_pc_src_out     = fetch_seq_reset_in ? PC_SRC_SEQ : pc_src;
  assign fetch_seq_ir_set_val_out = ir_set && !fetch_seq_reset_in;
  assign fetch_seq_ir_valid_out   = (state == HOLD);
  assign fetch_seq_err_out        = (state == ERROR);

`ifdef CORE101_FETCH_PERF_EN
  logic [31:0] perf_ins;
  logic [31:0] perf_stall;

  always_ff @(posedge fetch_seq_clock_in or posedge fetch_seq_reset_in) begin
    if (fetch_seq_reset_in) begin
      perf_ins   <= '0;
      perf_stall <= '0;
    end else if (state == HOLD) begin
      if (!fetch_seq_redirect_valid_in && !fetch_seq_stall_in) begin
        perf_ins <= perf_ins + 32'd1;
      end
      if (fetch_seq_stall_in) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end

  assign fetch_seq_perf_ins_out   = perf_ins;
  assign fetch_seq_perf_stall_out = perf_stall;
`endif

endmodule
